// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write arbiter: source encoding,
// the never-written register and the default starvation limit.
package rf_arb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_WB   = 2'd1,
        SRC_MDU  = 2'd2,
        SRC_DBG  = 2'd3
    } src_t;

    localparam logic [4:0]  REG_ZERO       = 5'd0;
    localparam int unsigned DEF_STARVE_LIM = 4;

endpackage

// File: rtl/rf_arb_starve_cnt.sv
// Saturating wait counter for one handshaked writer; o_hit flags that the
// counter holds the starvation limit after the coming edge.
module rf_arb_starve_cnt
    import rf_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM,
    parameter int unsigned CNT_W      = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_req,
    input  logic i_mask,
    input  logic i_grant,
    output logic o_hit
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    // A masked request is the one just acked; it neither waits nor restarts.
    always_comb begin
        if (!i_req || i_grant)
            w_cnt_nxt = '0;
        else if (i_mask || (r_cnt == LIM))
            w_cnt_nxt = r_cnt;
        else
            w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    assign o_hit = (w_cnt_nxt == LIM);

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_cnt <= '0;
        else
            r_cnt <= w_cnt_nxt;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Single register-file write port shared by pipeline writeback, the MDU and
// the debug loader, with starvation-bounded stalling of writeback.
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIM = DEF_STARVE_LIM,
    parameter int unsigned CNT_W      = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_wr,
    input  logic [4:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_stall,
    input  logic        i_mdu_req,
    input  logic [4:0]  i_mdu_addr,
    input  logic [31:0] i_mdu_data,
    output logic        o_mdu_ack,
    input  logic        i_dbg_req,
    input  logic [4:0]  i_dbg_addr,
    input  logic [31:0] i_dbg_data,
    output logic        o_dbg_ack,
    output logic        o_rf_wr,
    output logic [4:0]  o_rf_addr,
    output logic [31:0] o_rf_data
);

    logic        r_rf_wr;
    logic [4:0]  r_rf_addr;
    logic [31:0] r_rf_data;
    logic        r_mdu_ack;
    logic        r_dbg_ack;
    logic        r_rr_dbg;
    src_t        r_force;

    logic        w_mdu_v;
    logic        w_dbg_v;
    logic        w_mdu_hit;
    logic        w_dbg_hit;
    logic        w_forced;
    src_t        w_src;
    src_t        w_force_nxt;
    logic [4:0]  w_addr;
    logic [31:0] w_data;

    assign w_mdu_v = i_mdu_req & ~r_mdu_ack;
    assign w_dbg_v = i_dbg_req & ~r_dbg_ack;

    always_comb begin
        w_src = SRC_NONE;
        if ((r_force == SRC_MDU) && w_mdu_v)
            w_src = SRC_MDU;
        else if ((r_force == SRC_DBG) && w_dbg_v)
            w_src = SRC_DBG;
        else if (i_wb_wr)
            w_src = SRC_WB;
        else if (w_mdu_v && (!r_rr_dbg || !w_dbg_v))
            w_src = SRC_MDU;
        else if (w_dbg_v)
            w_src = SRC_DBG;
    end

    assign w_forced   = (r_force != SRC_NONE) && (w_src == r_force);
    assign o_wb_stall = w_forced & i_wb_wr;

    always_comb begin
        case (w_src)
            SRC_WB:  begin w_addr = i_wb_addr;  w_data = i_wb_data;  end
            SRC_MDU: begin w_addr = i_mdu_addr; w_data = i_mdu_data; end
            SRC_DBG: begin w_addr = i_dbg_addr; w_data = i_dbg_data; end
            default: begin w_addr = r_rf_addr;  w_data = r_rf_data;  end
        endcase
    end

    // A granted requester's counter clears, so re-evaluating the hit flags on
    // release hands force straight to a requester already waiting at the limit.
    always_comb begin
        w_force_nxt = r_force;
        if ((r_force == SRC_NONE) || w_forced) begin
            if (w_mdu_hit)
                w_force_nxt = SRC_MDU;
            else if (w_dbg_hit)
                w_force_nxt = SRC_DBG;
            else
                w_force_nxt = SRC_NONE;
        end
    end

    rf_arb_starve_cnt #(.STARVE_LIM(STARVE_LIM), .CNT_W(CNT_W)) u_mdu_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (i_mdu_req),
        .i_mask  (r_mdu_ack),
        .i_grant (w_src == SRC_MDU),
        .o_hit   (w_mdu_hit)
    );

    rf_arb_starve_cnt #(.STARVE_LIM(STARVE_LIM), .CNT_W(CNT_W)) u_dbg_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_req   (i_dbg_req),
        .i_mask  (r_dbg_ack),
        .i_grant (w_src == SRC_DBG),
        .o_hit   (w_dbg_hit)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rf_wr   <= 1'b0;
            r_rf_addr <= '0;
            r_rf_data <= '0;
            r_mdu_ack <= 1'b0;
            r_dbg_ack <= 1'b0;
            r_rr_dbg  <= 1'b0;
            r_force   <= SRC_NONE;
        end else begin
            r_rf_wr   <= (w_src != SRC_NONE) && (w_addr != REG_ZERO);
            r_rf_addr <= w_addr;
            r_rf_data <= w_data;
            r_mdu_ack <= (w_src == SRC_MDU);
            r_dbg_ack <= (w_src == SRC_DBG);
            r_force   <= w_force_nxt;
            if (w_src == SRC_MDU)
                r_rr_dbg <= 1'b1;
            else if (w_src == SRC_DBG)
                r_rr_dbg <= 1'b0;
        end
    end

    assign o_rf_wr   = r_rf_wr;
    assign o_rf_addr = r_rf_addr;
    assign o_rf_data = r_rf_data;
    assign o_mdu_ack = r_mdu_ack;
    assign o_dbg_ack = r_dbg_ack;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Vector-table bench for rf_write_arbiter; registered results are queued
// when a row is driven and compared one cycle later.
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_wr;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_stall;
    logic        mdu_req;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ack;
    logic        dbg_req;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;
    logic        dbg_ack;
    logic        rf_wr;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.STARVE_LIM(4), .CNT_W(4)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_wb_wr    (wb_wr),
        .i_wb_addr  (wb_addr),
        .i_wb_data  (wb_data),
        .o_wb_stall (wb_stall),
        .i_mdu_req  (mdu_req),
        .i_mdu_addr (mdu_addr),
        .i_mdu_data (mdu_data),
        .o_mdu_ack  (mdu_ack),
        .i_dbg_req  (dbg_req),
        .i_dbg_addr (dbg_addr),
        .i_dbg_data (dbg_data),
        .o_dbg_ack  (dbg_ack),
        .o_rf_wr    (rf_wr),
        .o_rf_addr  (rf_addr),
        .o_rf_data  (rf_data)
    );

    typedef struct {
        logic        wb;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mr;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        dr;
        logic [4:0]  da;
        logic [31:0] dd;
        logic        st;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        emack;
        logic        edack;
        logic        cad;
    } vec_t;

    typedef struct {
        int          row;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        logic        emack;
        logic        edack;
        logic        cad;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];

    function automatic vec_t mk(
        input logic wb, input logic [4:0] wa, input logic [31:0] wd,
        input logic mr, input logic [4:0] ma, input logic [31:0] md,
        input logic dr, input logic [4:0] da, input logic [31:0] dd,
        input logic st, input logic ew, input logic [4:0] ea, input logic [31:0] ed,
        input logic emack, input logic edack, input logic cad);
        vec_t v;
        v.wb = wb; v.wa = wa; v.wd = wd;
        v.mr = mr; v.ma = ma; v.md = md;
        v.dr = dr; v.da = da; v.dd = dd;
        v.st = st; v.ew = ew; v.ea = ea; v.ed = ed;
        v.emack = emack; v.edack = edack; v.cad = cad;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("row%0d rf_wr", e.row), 32'(rf_wr), 32'(e.ew));
            chk($sformatf("row%0d mdu_ack", e.row), 32'(mdu_ack), 32'(e.emack));
            chk($sformatf("row%0d dbg_ack", e.row), 32'(dbg_ack), 32'(e.edack));
            if (e.cad) begin
                chk($sformatf("row%0d rf_addr", e.row), 32'(rf_addr), 32'(e.ea));
                chk($sformatf("row%0d rf_data", e.row), rf_data, e.ed);
            end
        end
    endtask

    task automatic drive_idle();
        wb_wr = 0; wb_addr = '0; wb_data = '0;
        mdu_req = 0; mdu_addr = '0; mdu_data = '0;
        dbg_req = 0; dbg_addr = '0; dbg_data = '0;
    endtask

    task automatic run_row(input int idx, input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        wb_wr = v.wb; wb_addr = v.wa; wb_data = v.wd;
        mdu_req = v.mr; mdu_addr = v.ma; mdu_data = v.md;
        dbg_req = v.dr; dbg_addr = v.da; dbg_data = v.dd;
        @(negedge clk);
        pop_check();
        chk($sformatf("row%0d wb_stall", idx), 32'(wb_stall), 32'(v.st));
        e.row = idx; e.ew = v.ew; e.ea = v.ea; e.ed = v.ed;
        e.emack = v.emack; e.edack = v.edack; e.cad = v.cad;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1;
        drive_idle();
        @(posedge clk); @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("reset rf_wr", 32'(rf_wr), 32'h0);
        chk("reset rf_addr", 32'(rf_addr), 32'h0);
        chk("reset rf_data", rf_data, 32'h0);
        chk("reset mdu_ack", 32'(mdu_ack), 32'h0);
        chk("reset dbg_ack", 32'(dbg_ack), 32'h0);
        chk("reset wb_stall", 32'(wb_stall), 32'h0);

        // single WB write
        tbl.push_back(mk(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h1234, 0, 0, 1));
        // MDU and DBG together, MDU first from reset pointer
        tbl.push_back(mk(0, 0, 0, 1, 8, 32'hA, 1, 9, 32'hB, 0, 1, 8, 32'hA, 1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 8, 32'hA, 1, 9, 32'hB, 0, 1, 9, 32'hB, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 32'hB, 0, 0, 1));
        // debug write to $0: acked, never written
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 1, 0));
        // both requesters back-to-back: strict alternation
        for (int k = 0; k < 8; k++)
            tbl.push_back(mk(0, 0, 0, 1, 10, 32'hAA, 1, 11, 32'hBB, 0, 1,
                             (k % 2 == 0) ? 5'd10 : 5'd11,
                             (k % 2 == 0) ? 32'hAA : 32'hBB,
                             (k % 2 == 0), (k % 2 == 1), 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 11, 32'hBB, 0, 0, 1));
        // WB busy, MDU starves for 4 cycles then is forced in
        tbl.push_back(mk(1, 1, 32'h101, 1, 7, 32'h77, 0, 0, 0, 0, 1, 1, 32'h101, 0, 0, 1));
        tbl.push_back(mk(1, 2, 32'h102, 1, 7, 32'h77, 0, 0, 0, 0, 1, 2, 32'h102, 0, 0, 1));
        tbl.push_back(mk(1, 3, 32'h103, 1, 7, 32'h77, 0, 0, 0, 0, 1, 3, 32'h103, 0, 0, 1));
        tbl.push_back(mk(1, 4, 32'h104, 1, 7, 32'h77, 0, 0, 0, 0, 1, 4, 32'h104, 0, 0, 1));
        tbl.push_back(mk(1, 5, 32'h105, 1, 7, 32'h77, 0, 0, 0, 1, 1, 7, 32'h77, 1, 0, 1));
        tbl.push_back(mk(1, 5, 32'h105, 0, 7, 32'h77, 0, 0, 0, 0, 1, 5, 32'h105, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 32'h105, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++)
            run_row(i, tbl[i]);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        pop_check();

        // reset while MDU waits with its counter at 3
        @(posedge clk); #1;
        wb_wr = 1; wb_addr = 3; wb_data = 32'h33;
        mdu_req = 1; mdu_addr = 12; mdu_data = 32'hC0DE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("rst5 rf_wr", 32'(rf_wr), 32'h0);
                chk("rst5 rf_addr", 32'(rf_addr), 32'h0);
                chk("rst5 rf_data", rf_data, 32'h0);
                chk("rst5 dbg_ack", 32'(dbg_ack), 32'h0);
            end
            chk($sformatf("rst5 c%0d mdu_ack", k), 32'(mdu_ack), 32'h0);
            chk($sformatf("rst5 c%0d wb_stall", k), 32'(wb_stall), (k == 4) ? 32'h1 : 32'h0);
            @(posedge clk); #1;
        end
        mdu_req = 0;
        @(negedge clk);
        chk("rst5 grant mdu_ack", 32'(mdu_ack), 32'h1);
        chk("rst5 grant rf_addr", 32'(rf_addr), 32'd12);
        chk("rst5 grant rf_data", rf_data, 32'hC0DE);
        chk("rst5 wb resumes", 32'(wb_stall), 32'h0);
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        chk("rst5 single ack", 32'(mdu_ack), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (wr/addr3/data3) between three writers:
  - pipeline writeback (WB): primary, no handshake;
  - multiply/divide unit (MDU): req/ack;
  - debug/loader port (DBG): req/ack.
- Sits between the pipeline, MDU and debug bridge, and drives the register file's write port with registered outputs.
- Guarantees forward progress for MDU/DBG by stalling WB after a bounded wait.

Parameters:
- STARVE_LIM, 4: consecutive cycles an MDU/DBG request may wait with WB busy before WB is forcibly stalled (legal range 1..15).
- CNT_W, 4: width of the per-requester wait counters.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- wb_wr  in  1  WB write request, valid this cycle
- wb_addr  in  5  WB destination register
- wb_data  in  32  WB write data
- wb_stall  out  1  WB write not accepted this cycle; pipeline holds and re-presents it
- mdu_req  in  1  MDU write request, held until ack
- mdu_addr  in  5  MDU destination, stable while req
- mdu_data  in  32  MDU data, stable while req
- mdu_ack  out  1  one-cycle pulse: MDU write accepted
- dbg_req  in  1  debug write request, held until ack
- dbg_addr  in  5  debug destination
- dbg_data  in  32  debug data
- dbg_ack  out  1  one-cycle pulse: debug write accepted
- rf_wr  out  1  register-file write enable
- rf_addr  out  5  register-file write address
- rf_data  out  32  register-file write data

Behaviour:
- Reset (sync, high): rf_wr=0, rf_addr=0, rf_data=0, mdu_ack=0, dbg_ack=0, wb_stall=0. Counters=0, force=none, rr pointer=MDU.
  - Reset mid-request discards the request; the requester must re-present it after reset.
- Arbitration is combinational on cycle-t inputs; the winner is registered at the t/t+1 edge.
  - rf_* and ack are valid in cycle t+1.
  - Latency is 1 cycle for all writers.
- Masking: a requester whose ack is high in cycle t is ignored in cycle t.
  - This absorbs the req-drop latency.
  - A new request may be presented from t+1 on.
- Priority in cycle t:
  1. force==MDU or force==DBG: grant the forced requester. wb_stall=1; WB is not written.
  2. else wb_wr=1: grant WB. wb_stall=0.
  3. else round-robin between unmasked mdu_req/dbg_req, starting at the rr pointer. The pointer moves past the winner.
  4. else idle: rf_wr<=0, rf_addr/rf_data hold their last value.
- wb_stall is combinational: high only in a force cycle with wb_wr=1. With wb_wr=0 it stays 0.
- Wait counters (one each for MDU, DBG):
  - Increment when req is unmasked and not granted.
  - Clear on grant or when req=0.
  - Saturate at STARVE_LIM.
- Force register: set to a requester at the edge where its counter reaches STARVE_LIM.
  - If both reach it simultaneously, MDU is forced first; DBG is forced in the next cycle.
  - Force clears at the edge where the forced requester is granted.
- Address 0 writes (any source): granted and acked normally, but rf_wr<=0. $0 is never written.
- Registered rf_* is issued one cycle after the grant. The register file's internal bypass covers reads of the addressed register in the write cycle.
- Only one write per cycle, always. The losers' requests persist and are retried.

Decomposition:
- Shared package (rf_arb_pkg): source encoding enum {SRC_NONE, SRC_WB, SRC_MDU, SRC_DBG}, REG_ZERO=5'd0, default STARVE_LIM.
- One natural sub-module: rf_arb_starve_cnt. It holds the saturating wait counter and limit-hit flag and is instantiated twice, for MDU and DBG.

Test Plan:
1. After reset, wb_wr=1 with addr=5, data=0x1234 for 1 cycle -> next cycle rf_wr=1, rf_addr=5, rf_data=0x1234; wb_stall=0 throughout.
2. wb_wr=0, mdu_req and dbg_req both asserted in the same cycle (mdu addr 8/0xA, dbg addr 9/0xB) -> MDU written first (rr reset value), dbg_ack one cycle later. rf sequence: (8,0xA), then (9,0xB).
3. STARVE_LIM=4, wb_wr=1 continuously, mdu_req held -> after 4 waiting cycles wb_stall=1 for exactly 1 cycle. MDU write issued next cycle, mdu_ack pulses once, WB resumes.
4. dbg_req with addr=0, data=0xFFFFFFFF -> dbg_ack pulses; rf_wr stays 0.
5. Assert reset while mdu_req is pending and its counter is at 3 -> all outputs 0 the next cycle, counter cleared, no ack issued.
6. mdu_req and dbg_req held back-to-back for 8 cycles with WB idle -> grants alternate MDU, DBG, MDU, ...; no requester is acked twice in consecutive cycles.
